// File: rtl/b_lut_opcollect_pkg.sv
// Shared definitions for the xc.lut operand-collection stage: FSM encoding
// and the beat-index constants carried on in_beat.
package b_lut_opcollect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT3 = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic BEAT_RS12 = 1'b0;
  localparam logic BEAT_RS3  = 1'b1;

endpackage

// File: rtl/b_lut.sv
// Combinational xc.lut evaluator: each nibble of crs1 selects one of the
// sixteen nibbles of the 64-bit table {crs3, crs2}.
module b_lut (
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  input  logic [31:0] crs3,
  output logic [31:0] result
);

  logic [63:0] table_w;
  assign table_w = {crs3, crs2};

  for (genvar j = 0; j < 8; j++) begin : g_nib
    assign result[4*j +: 4] = table_w[{crs1[4*j +: 4], 2'b00} +: 4];
  end

endmodule

// File: rtl/b_lut_opcollect.sv
// Gathers rs1/rs2 (beat 0) and rs3 (beat 1) for xc.lut, evaluates the lookup
// and holds the tagged result until writeback accepts it.
module b_lut_opcollect
  import b_lut_opcollect_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_beat,
  input  logic [31:0]      in_d0,
  input  logic [31:0]      in_d1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             err,
  output state_t           dbg_state
);

  // Handshakes: a beat/result moves on the rising edge where valid && ready
  // are both high; a producer holds its payload stable until that edge, and
  // ready never depends combinationally on the matching valid.
  state_t             state, state_n;
  logic [31:0]        rs1_q, rs1_n, rs2_q, rs2_n, res_q, res_n, lut_res;
  logic [TAG_W-1:0]   tag_q, tag_n, otag_q, otag_n;
  logic               err_q, err_n;
  logic               in_hs, out_hs;

  b_lut u_lut (
    .crs1   (rs1_q),
    .crs2   (rs2_q),
    .crs3   (in_d0),
    .result (lut_res)
  );

  // DONE only accepts input when the result drains in the same cycle.
  assign in_ready   = !g_reset && ((state == DONE) ? out_ready : 1'b1);
  assign out_valid  = (state == DONE);
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign out_result = res_q;
  assign out_tag    = otag_q;
  assign err        = err_q;
  assign dbg_state  = state;

  always_comb begin
    state_n = state;
    rs1_n   = rs1_q;
    rs2_n   = rs2_q;
    tag_n   = tag_q;
    res_n   = res_q;
    otag_n  = otag_q;
    err_n   = err_q;
    if (flush) begin
      state_n = IDLE;
      err_n   = 1'b0;
    end else begin
      if (in_hs && in_beat == BEAT_RS12) begin
        rs1_n = in_d0;
        rs2_n = in_d1;
        tag_n = in_tag;
      end
      case (state)
        IDLE: begin
          if (in_hs && in_beat == BEAT_RS12) state_n = WAIT3;
          else if (in_hs)                   err_n   = 1'b1;
        end
        WAIT3: begin
          if (in_hs && in_beat == BEAT_RS3) begin
            res_n   = lut_res;
            otag_n  = tag_q;
            state_n = DONE;
          end else if (in_hs) begin
            err_n = 1'b1;
          end
        end
        DONE: begin
          if (out_hs) state_n = IDLE;
          if (in_hs && in_beat == BEAT_RS12) state_n = WAIT3;
          else if (in_hs)                   err_n   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state  <= IDLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      tag_q  <= '0;
      res_q  <= '0;
      otag_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      rs1_q  <= rs1_n;
      rs2_q  <= rs2_n;
      tag_q  <= tag_n;
      res_q  <= res_n;
      otag_q <= otag_n;
      err_q  <= err_n;
    end
  end

endmodule

// File: tb/tb_b_lut_opcollect.sv
// Directed bench for b_lut_opcollect: driver tasks issue beats, a negedge
// monitor pops expected {tag,result} pairs whenever a result transfers.
module tb_b_lut_opcollect;
  import b_lut_opcollect_pkg::*;

  localparam int TAG_W = 5;

  logic             g_clk = 1'b0;
  logic             g_reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_beat = 1'b0;
  logic [31:0]      in_d0 = '0;
  logic [31:0]      in_d1 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             err;
  state_t           dbg_state;

  logic [TAG_W+31:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  b_lut_opcollect #(.TAG_W(TAG_W)) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_beat    (in_beat),
    .in_d0      (in_d0),
    .in_d1      (in_d1),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge g_clk);
    #1;
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic send_beat(input logic b, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_beat  = b;
    in_d0    = d0;
    in_d1    = d1;
    in_tag   = tag;
    @(negedge g_clk);
    while (!in_ready && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycles(1);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge g_clk) begin
    if (!g_reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {27'd0, out_tag, out_result}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        check("out_tag_result", {27'd0, out_tag, out_result}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("rst_in_ready",   {63'd0, in_ready},  64'd0);
    check("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_tag",    {59'd0, out_tag},   64'd0);
    check("rst_err",        {63'd0, err},       64'd0);
    check("rst_state",      {62'd0, dbg_state}, {62'd0, IDLE});
    cycles(2);
    g_reset = 1'b0;
    cycles(1);
    out_ready = 1'b1;

    // identity table
    exp_q.push_back({5'd7, 32'h12345678});
    send_beat(BEAT_RS12, 32'h12345678, 32'h76543210, 5'd7);
    send_beat(BEAT_RS3,  32'hFEDCBA98, 32'h0, 5'd0);
    check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    wait_drain("drain_identity");

    // inverting table
    exp_q.push_back({5'd3, 32'hFFFFFFFF});
    send_beat(BEAT_RS12, 32'h00000000, 32'h89ABCDEF, 5'd3);
    send_beat(BEAT_RS3,  32'h01234567, 32'h0, 5'd0);
    exp_q.push_back({5'd4, 32'h00000000});
    send_beat(BEAT_RS12, 32'hFFFFFFFF, 32'h89ABCDEF, 5'd4);
    send_beat(BEAT_RS3,  32'h01234567, 32'h0, 5'd0);
    exp_q.push_back({5'd9, 32'hFFFFFFF0});
    send_beat(BEAT_RS12, 32'h0000000F, 32'h89ABCDEF, 5'd9);
    send_beat(BEAT_RS3,  32'h01234567, 32'h0, 5'd0);
    wait_drain("drain_invert");

    // backpressure, then drain and capture in the same cycle
    out_ready = 1'b0;
    exp_q.push_back({5'd11, 32'h76543210});
    send_beat(BEAT_RS12, 32'h76543210, 32'h76543210, 5'd11);
    send_beat(BEAT_RS3,  32'hFEDCBA98, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge g_clk);
      check("bp_out_valid",  {63'd0, out_valid}, 64'd1);
      check("bp_out_result", {32'd0, out_result}, 64'h76543210);
      check("bp_in_ready",   {63'd0, in_ready},  64'd0);
    end
    @(posedge g_clk);
    #1;
    out_ready = 1'b1;
    send_beat(BEAT_RS12, 32'h000000FF, 32'h89ABCDEF, 5'd12);
    check("bp_state_wait3", {62'd0, dbg_state}, {62'd0, WAIT3});
    check("bp_drained",     64'(exp_q.size()), 64'd0);
    exp_q.push_back({5'd12, 32'hFFFFFF00});
    send_beat(BEAT_RS3, 32'h01234567, 32'h0, 5'd0);
    wait_drain("drain_bp");

    // protocol error: beat 1 while idle
    send_beat(BEAT_RS3, 32'h11111111, 32'h0, 5'd0);
    check("perr_err",       {63'd0, err},       64'd1);
    check("perr_out_valid", {63'd0, out_valid}, 64'd0);
    check("perr_state",     {62'd0, dbg_state}, {62'd0, IDLE});
    exp_q.push_back({5'd13, 32'hA5A5A5A5});
    send_beat(BEAT_RS12, 32'hA5A5A5A5, 32'h76543210, 5'd13);
    send_beat(BEAT_RS3,  32'hFEDCBA98, 32'h0, 5'd0);
    wait_drain("drain_perr");
    check("perr_err_sticky", {63'd0, err}, 64'd1);

    // flush in WAIT3 clears err and discards the operation
    send_beat(BEAT_RS12, 32'h12345678, 32'h76543210, 5'd1);
    do_flush();
    check("flush_w3_state", {62'd0, dbg_state}, {62'd0, IDLE});
    check("flush_w3_err",   {63'd0, err},       64'd0);
    check("flush_w3_valid", {63'd0, out_valid}, 64'd0);

    // repeated beat 0 in WAIT3 replaces the held operands
    exp_q.push_back({5'd21, 32'h00000000});
    send_beat(BEAT_RS12, 32'h12345678, 32'h76543210, 5'd20);
    send_beat(BEAT_RS12, 32'hFFFFFFFF, 32'h89ABCDEF, 5'd21);
    check("replace_err", {63'd0, err}, 64'd1);
    send_beat(BEAT_RS3, 32'h01234567, 32'h0, 5'd0);
    wait_drain("drain_replace");
    do_flush();

    // flush in DONE with backpressure
    out_ready = 1'b0;
    send_beat(BEAT_RS12, 32'h12345678, 32'h76543210, 5'd2);
    send_beat(BEAT_RS3,  32'hFEDCBA98, 32'h0, 5'd0);
    check("flush_done_pre", {63'd0, out_valid}, 64'd1);
    do_flush();
    check("flush_done_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    cycles(3);

    // asynchronous reset between beat 0 and beat 1
    send_beat(BEAT_RS12, 32'h12345678, 32'h76543210, 5'd5);
    #2;
    g_reset = 1'b1;
    #1;
    check("arst_state",      {62'd0, dbg_state}, {62'd0, IDLE});
    check("arst_out_valid",  {63'd0, out_valid}, 64'd0);
    check("arst_out_result", {32'd0, out_result}, 64'd0);
    check("arst_in_ready",   {63'd0, in_ready},  64'd0);
    @(negedge g_clk);
    g_reset = 1'b0;
    cycles(1);
    send_beat(BEAT_RS3, 32'hFEDCBA98, 32'h0, 5'd0);
    check("arst_beat1_err",   {63'd0, err},       64'd1);
    check("arst_beat1_valid", {63'd0, out_valid}, 64'd0);
    cycles(3);
    wait_drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
